// File: rtl/cpu_control_unit.sv
// cpu_control_unit: Moore sequencer for the 16-bit RISC CPU (FETCH -> DECODE -> EXECUTE).
// Latency: 3 cycles per ALU/LD/ST/JMP/JR/BR instruction including FETCH, 2 cycles for NOP.
// Backpressure: none; memory is assumed to respond in the same cycle, and HALT holds until reset.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   ir                instruction register: [15:12] opcode, [11:9] sub-op / branch condition mask
//   C, N, Z           ALU flags from the IDP, sampled when leaving EXEC_ALU
//   pc_ld, pc_sel,    PC control: load from the PC mux (0 = jump target, 1 = ALU out), or increment
//   pc_inc
//   ir_ld, adr_sel    IR load strobe; address mux (0 = PC, 1 = Reg_Out)
//   W_En, S_Sel       register file write; IDP S mux (0 = register S, 1 = memory data)
//   mem_rd, mem_wr    memory read / write enables
//   halted, state     HALT indicator and the current state code for debug
//   flags_q           latched {C,N,Z} from the most recent ALU instruction
module cpu_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        ir,
  input  logic               C,
  input  logic               N,
  input  logic               Z,
  output logic               pc_ld,
  output logic               pc_sel,
  output logic               pc_inc,
  output logic               ir_ld,
  output logic               adr_sel,
  output logic               W_En,
  output logic               S_Sel,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               halted,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         flags_q
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_ALU = 4'd3,
    S_LOAD     = 4'd4,
    S_STORE    = 4'd5,
    S_JMP      = 4'd6,
    S_JR       = 4'd7,
    S_BR       = 4'd8,
    S_HALT     = 4'd9
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   br_taken;

  // Only the opcode and sub-op field steer the sequencer; the operand bits are for the EU.
  logic unused_ir;
  assign unused_ir = ^ir[8:0];

  // IR and flags_q are both stable across the DECODE -> BR edge, so the branch decision can be
  // made while entering BR and registered with the other strobes.
  assign br_taken = |(ir[11:9] & flags_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          4'hC:    state_d = ir[11] ? S_STORE : S_LOAD;
          4'hD:    state_d = ir[11] ? S_JR    : S_JMP;
          4'hE:    state_d = S_BR;
          4'hF:    state_d = ir[11] ? S_HALT  : S_FETCH;
          default: state_d = S_EXEC_ALU;
        endcase
      end
      S_EXEC_ALU, S_LOAD, S_STORE, S_JMP, S_JR, S_BR: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  // Strobes are registered from the next state, giving Moore outputs that are a pure function of
  // the current state while still clearing asynchronously the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      flags_q <= 3'b000;
      pc_ld   <= 1'b0;
      pc_sel  <= 1'b0;
      pc_inc  <= 1'b0;
      ir_ld   <= 1'b0;
      adr_sel <= 1'b0;
      W_En    <= 1'b0;
      S_Sel   <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC_ALU) begin
        flags_q <= {C, N, Z};
      end

      pc_ld   <= 1'b0;
      pc_sel  <= 1'b0;
      pc_inc  <= 1'b0;
      ir_ld   <= 1'b0;
      adr_sel <= 1'b0;
      W_En    <= 1'b0;
      S_Sel   <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      halted  <= 1'b0;

      case (state_d)
        S_FETCH: begin
          mem_rd <= 1'b1;
          ir_ld  <= 1'b1;
          pc_inc <= 1'b1;
        end
        S_EXEC_ALU: begin
          W_En <= 1'b1;
        end
        S_LOAD: begin
          adr_sel <= 1'b1;
          mem_rd  <= 1'b1;
          S_Sel   <= 1'b1;
          W_En    <= 1'b1;
        end
        S_STORE: begin
          adr_sel <= 1'b1;
          mem_wr  <= 1'b1;
        end
        S_JMP: begin
          pc_ld <= 1'b1;
        end
        S_JR: begin
          pc_ld  <= 1'b1;
          pc_sel <= 1'b1;
        end
        S_BR: begin
          pc_ld <= br_taken;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        C, N, Z;
  logic        pc_ld, pc_sel, pc_inc, ir_ld, adr_sel, W_En, S_Sel, mem_rd, mem_wr, halted;
  logic [3:0]  state;
  logic [2:0]  flags_q;

  int checks;
  int passed;
  int wr_count;
  int wr_before;

  // Strobe vector order: pc_ld pc_sel pc_inc ir_ld adr_sel W_En S_Sel mem_rd mem_wr halted
  localparam logic [9:0] ST_NONE  = 10'b0000000000;
  localparam logic [9:0] ST_FETCH = 10'b0011000100;
  localparam logic [9:0] ST_ALU   = 10'b0000010000;
  localparam logic [9:0] ST_LOAD  = 10'b0000111100;
  localparam logic [9:0] ST_STORE = 10'b0000100010;
  localparam logic [9:0] ST_JMP   = 10'b1000000000;
  localparam logic [9:0] ST_JR    = 10'b1100000000;
  localparam logic [9:0] ST_HALT  = 10'b0000000001;

  logic [9:0] strobes;
  assign strobes = {pc_ld, pc_sel, pc_inc, ir_ld, adr_sel, W_En, S_Sel, mem_rd, mem_wr, halted};

  cpu_control_unit #(.STATE_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .ir      (ir),
    .C       (C),
    .N       (N),
    .Z       (Z),
    .pc_ld   (pc_ld),
    .pc_sel  (pc_sel),
    .pc_inc  (pc_inc),
    .ir_ld   (ir_ld),
    .adr_sel (adr_sel),
    .W_En    (W_En),
    .S_Sel   (S_Sel),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .halted  (halted),
    .state   (state),
    .flags_q (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory write model: a write lands on any rising edge where mem_wr is high.
  initial wr_count = 0;
  always @(posedge clk) begin
    if (mem_wr) wr_count = wr_count + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input logic [3:0] exp_state, input logic [9:0] exp_strobes);
    chk({tag, ".state"}, {12'd0, state}, {12'd0, exp_state});
    chk({tag, ".strobes"}, {6'd0, strobes}, {6'd0, exp_strobes});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b0;
    ir     = 16'h0000;
    C = 1'b0; N = 1'b0; Z = 1'b0;

    // Reset held
    repeat (2) @(posedge clk);
    #1;
    chk_st("rst_hold", 4'd0, ST_NONE);
    chk("rst_flags", {13'd0, flags_q}, 16'd0);

    // Release between edges: one cycle in RESET, then FETCH, then DECODE
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_st("rel_reset", 4'd0, ST_NONE);
    ir = 16'h1288;
    step(); chk_st("fetch1", 4'd1, ST_FETCH);
    step(); chk_st("decode1", 4'd2, ST_NONE);
    C = 1'b1; N = 1'b0; Z = 1'b0;
    step(); chk_st("alu1", 4'd3, ST_ALU);
    step(); chk_st("alu1_done", 4'd1, ST_FETCH);
    chk("alu1_flags", {13'd0, flags_q}, 16'h0004);
    C = 1'b0;

    // LOAD
    ir = 16'hC048;
    step(); chk_st("ld_dec", 4'd2, ST_NONE);
    step(); chk_st("ld", 4'd4, ST_LOAD);
    step(); chk_st("ld_done", 4'd1, ST_FETCH);

    // STORE: exactly one memory write, flags untouched
    ir = 16'hC848;
    wr_before = wr_count;
    step(); chk_st("st_dec", 4'd2, ST_NONE);
    step(); chk_st("st", 4'd5, ST_STORE);
    step(); chk_st("st_done", 4'd1, ST_FETCH);
    chk("st_writes", 16'(wr_count - wr_before), 16'd1);
    chk("st_flags", {13'd0, flags_q}, 16'h0004);

    // ALU setting Z only -> flags 001
    ir = 16'h0000;
    step(); chk_st("aluz_dec", 4'd2, ST_NONE);
    C = 1'b0; N = 1'b0; Z = 1'b1;
    step(); chk_st("aluz", 4'd3, ST_ALU);
    step(); chk("aluz_flags", {13'd0, flags_q}, 16'h0001);
    Z = 1'b0;

    // BR mask Z with Z latched -> taken
    ir = 16'hE205;
    step(); chk_st("brz_dec", 4'd2, ST_NONE);
    step(); chk_st("brz_taken", 4'd8, ST_JMP);
    step(); chk_st("brz_done", 4'd1, ST_FETCH);

    // ALU setting C,N -> flags 110
    ir = 16'h2000;
    step();
    C = 1'b1; N = 1'b1; Z = 1'b0;
    step(); chk_st("alucn", 4'd3, ST_ALU);
    step(); chk("alucn_flags", {13'd0, flags_q}, 16'h0006);
    C = 1'b0; N = 1'b0;

    // BR mask Z with flags 110 -> not taken
    ir = 16'hE205;
    step();
    step(); chk_st("brz_not", 4'd8, ST_NONE);
    step(); chk_st("brz_not_done", 4'd1, ST_FETCH);

    // BR mask 000 -> never taken
    ir = 16'hE005;
    step();
    step(); chk_st("br0", 4'd8, ST_NONE);
    step();

    // BR mask C with C latched -> taken
    ir = 16'hE805;
    step();
    step(); chk_st("brc", 4'd8, ST_JMP);
    step(); chk("br_flags", {13'd0, flags_q}, 16'h0006);

    // JR and JMP
    ir = 16'hD800;
    step();
    step(); chk_st("jr", 4'd7, ST_JR);
    step();
    ir = 16'hD000;
    step();
    step(); chk_st("jmp", 4'd6, ST_JMP);
    step(); chk_st("jmp_done", 4'd1, ST_FETCH);

    // NOP returns to FETCH after DECODE
    ir = 16'hF000;
    step(); chk_st("nop_dec", 4'd2, ST_NONE);
    step(); chk_st("nop_done", 4'd1, ST_FETCH);

    // HALT is sticky
    ir = 16'hF800;
    step();
    step(); chk_st("halt", 4'd9, ST_HALT);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_st("halt_hold", 4'd9, ST_HALT);
    end

    // Leave HALT via reset, then NOP takes 2 cycles back to FETCH
    reset = 1'b0;
    #1;
    chk_st("halt_rst", 4'd0, ST_NONE);
    chk("halt_rst_flags", {13'd0, flags_q}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    ir = 16'hF000;
    step(); chk_st("re_fetch", 4'd1, ST_FETCH);
    step(); chk_st("re_nop_dec", 4'd2, ST_NONE);
    step(); chk_st("re_nop_done", 4'd1, ST_FETCH);

    // Reset asserted mid-STORE: strobes drop at once, no write lands
    ir = 16'h1288;
    step();
    C = 1'b1;
    step();
    step(); chk("pre_st_flags", {13'd0, flags_q}, 16'h0004);
    C = 1'b0;
    ir = 16'hC848;
    step();
    step(); chk_st("st2", 4'd5, ST_STORE);
    wr_before = wr_count;
    #2;
    reset = 1'b0;
    #1;
    chk_st("st_abort", 4'd0, ST_NONE);
    chk("st_abort_flags", {13'd0, flags_q}, 16'd0);
    step();
    chk("st_abort_writes", 16'(wr_count - wr_before), 16'd0);
    chk_st("st_abort_hold", 4'd0, ST_NONE);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
